// File: rtl/mesi_bus_sched.sv
// Purpose: round-robin owner of the shared MESI snooping bus; sequences ADDR -> SNOOP -> DATA -> DONE per transaction.
// Latency: req to grant 1 cycle; grant to txn_done SNOOP_LAT+1 (BusUpgr), SNOOP_LAT+2 (dirty hit), SNOOP_LAT+2+k (memory).
// Backpressure: req is a level held by the cache until granted; DATA stalls on mem_valid (MESI_BUS_TIMEOUT_EN adds a watchdog).
module mesi_bus_sched #(
    parameter int N         = 2,
    parameter int SNOOP_LAT = 2,
    parameter int OW        = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [2*N-1:0] req_cmd,
    input  logic           mem_valid,
    input  logic           snoop_dirty,
    output logic [N-1:0]   grant,
    output logic [OW-1:0]  owner,
    output logic [1:0]     cur_cmd,
    output logic           bus_busy,
    output logic           snoop_strobe,
    output logic           txn_done,
    output logic           txn_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_SNOOP = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] CMD_UPGR = 2'b10;
    localparam int         IW       = (N > 1) ? $clog2(N) : 1;

    logic [2:0]    state;
    logic [OW-1:0] owner_q;
    logic [1:0]    cmd_q;
    logic [OW-1:0] last;
    logic [3:0]    cnt;
    logic          dirty_q;

    logic [IW-1:0] scan_idx;
    logic [OW-1:0] win;
    logic [1:0]    win_cmd;
    logic          win_vld;
    logic          cache_sup;
    logic          data_timeout;

    // Round-robin pick: first requester after last, wrapping; smallest offset wins.
    always_comb begin
        scan_idx = '0;
        win      = '0;
        win_cmd  = '0;
        win_vld  = 1'b0;
        for (int i = N; i >= 1; i--) begin
            scan_idx = IW'((int'(last) + i) % N);
            if (req[scan_idx]) begin
                win     = OW'(scan_idx);
                win_cmd = req_cmd[{scan_idx, 1'b0} +: 2];
                win_vld = 1'b1;
            end
        end
    end

    // A dirty snoop on a read means the owning cache drives the data in one cycle.
    assign cache_sup = dirty_q && !cmd_q[1];

`ifdef MESI_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;
    logic          to_q;

    assign data_timeout = (state == S_DATA) && !cache_sup && !mem_valid
                          && (tcnt == TW'(TIMEOUT - 1));

    // Watchdog: count DATA cycles; flag an abort for the DONE cycle that follows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
            to_q <= 1'b0;
        end else begin
            tcnt <= (state == S_DATA) ? tcnt + 1'b1 : '0;
            to_q <= data_timeout;
        end
    end

    assign txn_err = to_q && (state == S_DONE);
`else
    assign data_timeout = 1'b0;
    assign txn_err      = 1'b0;
`endif

    // Transaction FSM: grant in IDLE, hold owner/command until DONE, then advance the pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            owner_q <= '0;
            cmd_q   <= '0;
            last    <= OW'(N - 1);
            cnt     <= '0;
            dirty_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        owner_q <= win;
                        cmd_q   <= win_cmd;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    cnt   <= 4'(SNOOP_LAT - 1);
                    state <= S_SNOOP;
                end
                S_SNOOP: begin
                    if (cnt == 4'd0) begin
                        dirty_q <= snoop_dirty;
                        state   <= (cmd_q == CMD_UPGR) ? S_DONE : S_DATA;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DATA: begin
                    if (cache_sup || mem_valid || data_timeout) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    last  <= owner_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are gated by bus_busy so everything reads 0 while idle.
    assign bus_busy     = (state != S_IDLE);
    assign grant        = bus_busy ? (N'(1) << owner_q) : '0;
    assign owner        = bus_busy ? owner_q : '0;
    assign cur_cmd      = bus_busy ? cmd_q : '0;
    assign snoop_strobe = (state == S_ADDR);
    assign txn_done     = (state == S_DONE);

endmodule

// File: tb/tb_mesi_bus_sched.sv
// Directed bench for mesi_bus_sched: scoreboard of expected owner/latency/error per transaction,
// checked by a monitor when grant rises and when txn_done pulses; direct checks in the stimulus.
// Build with MESI_BUS_TIMEOUT_EN to include the watchdog scenario.
module tb_mesi_bus_sched;

    localparam int N         = 2;
    localparam int SNOOP_LAT = 2;
    localparam int OW        = 1;
    localparam int TIMEOUT   = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [2*N-1:0] req_cmd;
    logic           mem_valid;
    logic           snoop_dirty;
    logic [N-1:0]   grant;
    logic [OW-1:0]  owner;
    logic [1:0]     cur_cmd;
    logic           bus_busy;
    logic           snoop_strobe;
    logic           txn_done;
    logic           txn_err;

    mesi_bus_sched #(.N(N), .SNOOP_LAT(SNOOP_LAT), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .mem_valid(mem_valid),
        .snoop_dirty(snoop_dirty), .grant(grant), .owner(owner), .cur_cmd(cur_cmd),
        .bus_busy(bus_busy), .snoop_strobe(snoop_strobe), .txn_done(txn_done), .txn_err(txn_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int lat;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   grant_cyc = 0;
    int   ndone = 0;
    bit   busy_prev = 1'b0;
    int   model_last = N - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (txn_done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, {31'd0, txn_done}, 32'd1);
    endtask

    function automatic exp_t mk(input int o, input int l, input bit er);
        exp_t x;
        x.owner = o;
        x.lat   = l;
        x.err   = er;
        return x;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor: grant order at each grant, owner/latency/error at each txn_done.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus_busy === 1'b1 && !busy_prev) begin
                grant_cyc = cyc;
                chk("mon_strobe_at_grant", {31'd0, snoop_strobe}, 32'd1);
                if (exp_q.size() == 0) chk("mon_unexpected_grant", {31'd0, bus_busy}, 32'd0);
                else chk("mon_grant_order", {30'd0, grant}, 32'd1 << exp_q[0].owner);
            end
            if (txn_done === 1'b1) begin
                ndone++;
                if (exp_q.size() == 0) chk("mon_unexpected_done", {31'd0, txn_done}, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("mon_done_owner", {31'd0, owner}, e.owner);
                    chk("mon_done_latency", cyc - grant_cyc, e.lat);
                    chk("mon_done_err", {31'd0, txn_err}, {31'd0, e.err});
                end
            end
        end
        busy_prev = (bus_busy === 1'b1);
    end

    initial begin
        #2_000_000;
        $error("FAIL global_timeout observed=still running expected=finished");
        $fatal(1);
    end

    initial begin
        int own;
        int done_base;
        rst = 1'b0; req = '0; req_cmd = '0; mem_valid = 1'b0; snoop_dirty = 1'b0;
        step(2);
        // Reset state
        chk("rst_grant", {30'd0, grant}, 0);
        chk("rst_owner", {31'd0, owner}, 0);
        chk("rst_cur_cmd", {30'd0, cur_cmd}, 0);
        chk("rst_busy", {31'd0, bus_busy}, 0);
        chk("rst_strobe", {31'd0, snoop_strobe}, 0);
        chk("rst_done", {31'd0, txn_done}, 0);
        chk("rst_err", {31'd0, txn_err}, 0);
        rst = 1'b1;
        step(1);

        // 1: cache 0 BusRd, memory answers after 3 wait cycles in DATA
        req = 2'b01; req_cmd = 4'b0000;
        exp_q.push_back(mk(0, SNOOP_LAT + 2 + 3, 1'b0));
        step(1);
        chk("t1_grant", {30'd0, grant}, 2'b01);
        chk("t1_busy", {31'd0, bus_busy}, 1);
        req = 2'b00; req_cmd = 4'b1111;
        step(1);
        chk("t1_strobe_single", {31'd0, snoop_strobe}, 0);
        chk("t1_cmd_latched", {30'd0, cur_cmd}, 2'b00);
        step(SNOOP_LAT + 3);
        chk("t1_not_early", {31'd0, txn_done}, 0);
        mem_valid = 1'b1;
        step(1);
        chk("t1_done", {31'd0, txn_done}, 1);
        chk("t1_grant_in_done", {30'd0, grant}, 2'b01);
        mem_valid = 1'b0;
        step(1);
        chk("t1_release_grant", {30'd0, grant}, 0);
        chk("t1_release_busy", {31'd0, bus_busy}, 0);
        model_last = 0;

        // 2: both caches request continuously with mem_valid high: strict rotation, one idle gap
        req = 2'b11; req_cmd = 4'b0000; mem_valid = 1'b1;
        done_base = ndone;
        for (int k = 0; k < 4; k++) begin
            own = (model_last + 1) % N;
            model_last = own;
            exp_q.push_back(mk(own, SNOOP_LAT + 2, 1'b0));
        end
        model_last = 0;
        step(1);
        for (int k = 0; k < 4; k++) begin
            own = (model_last + 1) % N;
            model_last = own;
            chk("t2_grant", {30'd0, grant}, 32'd1 << own);
            wait_done("t2_wait_done", 50);
            if (k == 3) req = 2'b00;
            step(1);
            chk("t2_gap", {31'd0, bus_busy}, 0);
            step(1);
        end
        chk("t2_quiet", {31'd0, bus_busy}, 0);
        chk("t2_done_count", ndone - done_base, 4);
        mem_valid = 1'b0;

        // 3: cache 1 BusUpgr, memory never consulted
        req = 2'b10; req_cmd = 4'b1000;
        exp_q.push_back(mk(1, SNOOP_LAT + 1, 1'b0));
        step(1);
        chk("t3_grant", {30'd0, grant}, 2'b10);
        chk("t3_cur_cmd", {30'd0, cur_cmd}, 2'b10);
        req = 2'b00;
        step(SNOOP_LAT + 1);
        chk("t3_done", {31'd0, txn_done}, 1);
        step(1);
        chk("t3_release", {31'd0, bus_busy}, 0);
        model_last = 1;

        // 4: cache 0 BusRdX, dirty snoop on last SNOOP cycle, memory silent
        req = 2'b01; req_cmd = 4'b0001;
        exp_q.push_back(mk(0, SNOOP_LAT + 2, 1'b0));
        step(1);
        chk("t4_grant", {30'd0, grant}, 2'b01);
        req = 2'b00;
        step(SNOOP_LAT);
        snoop_dirty = 1'b1;
        step(1);
        snoop_dirty = 1'b0;
        step(1);
        chk("t4_done", {31'd0, txn_done}, 1);
        step(1);
        model_last = 0;

        // 5: async reset during SNOOP with cache 1 owning; pointer returns to N-1
        req = 2'b10; req_cmd = 4'b0000;
        exp_q.push_back(mk(1, 0, 1'b0));
        step(1);
        chk("t5_grant", {30'd0, grant}, 2'b10);
        step(1);
        rst = 1'b0;
        #1;
        chk("t5_rst_grant", {30'd0, grant}, 0);
        chk("t5_rst_busy", {31'd0, bus_busy}, 0);
        chk("t5_rst_done", {31'd0, txn_done}, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1; req = 2'b11; mem_valid = 1'b1;
        exp_q.push_back(mk(0, SNOOP_LAT + 2, 1'b0));
        step(1);
        chk("t5_first_after_rst", {30'd0, grant}, 2'b01);
        req = 2'b00;
        wait_done("t5_wait_done", 50);
        mem_valid = 1'b0;
        step(1);
        model_last = 0;

`ifdef MESI_BUS_TIMEOUT_EN
        // 6: watchdog abort of a BusRd that memory never answers; other requester goes next
        req = 2'b11; req_cmd = 4'b0000;
        exp_q.push_back(mk(1, SNOOP_LAT + 1 + TIMEOUT, 1'b1));
        exp_q.push_back(mk(0, SNOOP_LAT + 2, 1'b0));
        step(1);
        chk("t6_grant", {30'd0, grant}, 2'b10);
        wait_done("t6_wait_abort", TIMEOUT + 20);
        chk("t6_err", {31'd0, txn_err}, 1);
        mem_valid = 1'b1;
        step(1);
        chk("t6_release", {31'd0, bus_busy}, 0);
        step(1);
        chk("t6_next_grant", {30'd0, grant}, 2'b01);
        req = 2'b00;
        wait_done("t6_wait_done", 50);
        chk("t6_no_err", {31'd0, txn_err}, 0);
        mem_valid = 1'b0;
        step(1);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
